// File: rtl/day_counter_if.sv
// Day counter bus: calendar context and strobes in, day and pulses out.
// Signalling is strobe-based rather than valid/ready: inc_day and load are
// sampled on every rising clk edge, and each sampled high counts as one
// request. There is no back-pressure, so the counter always accepts.
// o_inc_month and o_load_err are one-clock pulses. o_day and o_month_err
// are level outputs. Every output is registered.
interface day_counter_if;
  logic       inc_day;
  logic [3:0] month;
  logic [11:0] year;
  logic       load;
  logic [4:0] load_day;
  logic [4:0] o_day;
  logic       o_inc_month;
  logic       o_load_err;
  logic       o_month_err;

  // Driver side (month counter / stimulus).
  modport master (
    output inc_day, month, year, load, load_day,
    input  o_day, o_inc_month, o_load_err, o_month_err
  );

  // Day counter side.
  modport slave (
    input  inc_day, month, year, load, load_day,
    output o_day, o_inc_month, o_load_err, o_month_err
  );
endinterface

// File: rtl/day_counter.sv
// Day-of-month counter with leap-year aware wrap, validated load and
// month-range error flag. All outputs are registered with one clock of latency.
module day_counter #(
  parameter int RESET_DAY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  day_counter_if.slave   bus
);

  // An out-of-range reset day falls back to the 1st.
  localparam logic [4:0] RST_DAY =
    (RESET_DAY >= 1 && RESET_DAY <= 28) ? 5'(RESET_DAY) : 5'd1;

  logic [4:0] day_q, day_d;
  logic       inc_month_q, inc_month_d;
  logic       load_err_q, load_err_d;
  logic       month_err_q, month_err_d;

  logic       leap;
  logic       month_ok;
  logic [4:0] dim;

  // Calendar context: leap year, month validity and days in the current month.
  always_comb begin
    leap     = (year_mod(12'd4) == 12'd0) &&
               ((year_mod(12'd100) != 12'd0) || (year_mod(12'd400) == 12'd0));
    month_ok = (bus.month >= 4'd1) && (bus.month <= 4'd12);
    dim      = 5'd31;
    case (bus.month)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = leap ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  end

  function automatic logic [11:0] year_mod(input logic [11:0] m);
    return bus.year % m;
  endfunction

  // Next-state: load has priority over inc_day, so an inc_day arriving with a
  // load is dropped. The ">=" wrap also recovers a day left above dim after
  // a month or year change.
  always_comb begin
    day_d       = day_q;
    inc_month_d = 1'b0;
    load_err_d  = 1'b0;
    month_err_d = !month_ok;
    if (bus.load) begin
      if ((bus.load_day != 5'd0) && (bus.load_day <= dim)) begin
        day_d = bus.load_day;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.inc_day) begin
      if (day_q >= dim) begin
        day_d       = 5'd1;
        inc_month_d = 1'b1;
      end else begin
        day_d = day_q + 5'd1;
      end
    end
  end

  // State registers. The asynchronous reset also cuts any pulse in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q       <= RST_DAY;
      inc_month_q <= 1'b0;
      load_err_q  <= 1'b0;
      month_err_q <= 1'b0;
    end else begin
      day_q       <= day_d;
      inc_month_q <= inc_month_d;
      load_err_q  <= load_err_d;
      month_err_q <= month_err_d;
    end
  end

  assign bus.o_day       = day_q;
  assign bus.o_inc_month = inc_month_q;
  assign bus.o_load_err  = load_err_q;
  assign bus.o_month_err = month_err_q;

endmodule

// File: doc/day_counter.md
DAY_COUNTER -- requirements
Module: day_counter

Interface
REQ-001 SHALL provide parameter RESET_DAY, default 1, day-of-month value loaded on reset; legal range 1..28.
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port inc_day  input  1  day-advance strobe, sampled each clk edge.
REQ-005 SHALL provide port month  input  4  current month (1..12) from the month counter.
REQ-006 SHALL provide port year  input  12  current year (0..4095), used for leap determination.
REQ-007 SHALL provide port load  input  1  day-set strobe, sampled each clk edge.
REQ-008 SHALL provide port load_day  input  5  day value applied when load=1.
REQ-009 SHALL provide port o_day  output  5  registered day of month, 1..31.
REQ-010 SHALL provide port o_inc_month  output  1  registered one-clk pulse, drives the month counter's inc_month.
REQ-011 SHALL provide port o_load_err  output  1  registered one-clk pulse, rejected load.
REQ-012 SHALL provide port o_month_err  output  1  registered, high while month input is outside 1..12.

Function
REQ-013 SHALL compute leap = (year mod 4 == 0) and ((year mod 100 != 0) or (year mod 400 == 0)); year 0 is leap.
REQ-014 SHALL compute dim (days in month): 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 29 for 2 when leap, else 28.
REQ-015 SHALL use dim = 31 for month values 0 and 13..15 and set o_month_err = 1 on the next clk edge; o_month_err SHALL clear on the first clk edge where month is 1..12.
REQ-016 SHALL, on a clk edge with load=0 and inc_day=1 and o_day < dim, set o_day = o_day + 1 with o_inc_month = 0.
REQ-017 SHALL, on a clk edge with load=0 and inc_day=1 and o_day >= dim, set o_day = 1 and o_inc_month = 1 for exactly that one cycle.
REQ-018 SHALL use the ">= dim" compare so that an o_day left above dim by a month/year change wraps to 1 on the next inc_day, with one o_inc_month pulse.
REQ-019 SHALL leave o_day unchanged when neither inc_day nor load is asserted, even if o_day > dim.
REQ-020 SHALL count each clk edge where inc_day=1 as one advance; inc_day held high N cycles yields N advances.
REQ-021 SHALL, on a clk edge with load=1 and 1 <= load_day <= dim (dim from the same-cycle month/year), set o_day = load_day, o_inc_month = 0, o_load_err = 0.
REQ-022 SHALL, on a clk edge with load=1 and load_day = 0 or load_day > dim, hold o_day, set o_inc_month = 0, and pulse o_load_err = 1 for one cycle.
REQ-023 SHALL give load priority over inc_day; the inc_day on a cycle with load=1 is discarded, not deferred.
REQ-024 SHALL deassert o_inc_month and o_load_err on every clk edge not meeting REQ-017 / REQ-022 respectively.
REQ-025 SHALL have latency one clk from strobe to updated o_day / pulse outputs; no combinational input-to-output paths.

Reset
REQ-026 SHALL, while rst_n = 0, force o_day = RESET_DAY (or 1 if RESET_DAY is outside 1..28), o_inc_month = 0, o_load_err = 0, o_month_err = 0, asynchronously.
REQ-027 SHALL, when rst_n is asserted mid-pulse, drop o_inc_month immediately; no pulse SHALL be emitted on or after rst_n deassertion without a new wrap.
REQ-028 SHALL ignore inc_day and load on the first clk edge only if rst_n is still low at that edge; the first edge with rst_n high is fully functional.

Verification
REQ-029 SHALL cover: month=2, year=2024, o_day=28, inc_day -> o_day=29, no pulse; inc_day -> o_day=1, o_inc_month=1 one cycle.
REQ-030 SHALL cover: month=2, years 1900 and 2000, o_day=28, inc_day -> 1900: o_day=1 with pulse; 2000: o_day=29, no pulse.
REQ-031 SHALL cover: month=4, o_day=31 via load at month=3, then inc_day -> o_day=1, o_inc_month=1.
REQ-032 SHALL cover: month=6, load=1 with load_day=31 and inc_day=1 same cycle -> o_day unchanged, o_load_err=1 one cycle, no increment.
REQ-033 SHALL cover: month=12, o_day=31, inc_day held 3 cycles -> o_day sequence 1,2,3, exactly one o_inc_month pulse.
REQ-034 SHALL cover: rst_n low for one cycle while o_inc_month=1 -> o_inc_month=0 and o_day=RESET_DAY immediately; month=0 afterwards -> o_month_err=1 on next edge.
